lcd1602_responder: RTL and testbench
====================================

# lcd1602_responder

Synthesizable responder for the HD44780-style 8-bit LCD1602 write bus (rs/rw/en/data) driven by our display controllers. It samples each transfer on the falling edge of lcd_en, decodes instructions and data writes, and maintains a 32-character shadow DDRAM plus display-control flags. A downstream text renderer, or a testbench scoreboard, reads the screen through a registered read port. It sits on the far end of the LCD bus, in the fast clk domain.

## Interface
- BUSY_CYCLES, default 2000: busy duration after a normal transfer (40 us at 50 MHz).
- CLR_CYCLES, default 82000: busy duration after Clear Display or Return Home (1.64 ms).
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, asynchronous, active-low.
- lcd_rs  in  1  register select: 0 = instruction, 1 = data.
- lcd_rw  in  1  0 = write; 1 = read, and read transfers are ignored.
- lcd_en  in  1  strobe, asynchronous to clk; sampled on its falling edge.
- lcd_data  in  8  bus data.
- rd_addr  in  5  screen cell: 0-15 is line 1, 16-31 is line 2.
- rd_char  out  8  DDRAM contents at rd_addr; registered.
- disp_on, cursor_on, blink_on  out  1 each  Display Control bits D, C, B.
- cursor_pos  out  7  address counter (AC).
- busy  out  1  transfer execution in progress.
- cmd_err  out  1  one-cycle pulse when a transfer is dropped.
- init_done  out  1  sticky; set by Function Set with DL=1 and N=1.

## Operation
- lcd_en, lcd_rs, lcd_rw and lcd_data each pass through a 2-flop synchronizer. A third register on lcd_en detects the falling edge (sync2=0, sync3=1).
- On a detected edge:
  - rw=1: ignore the transfer.
  - busy=1: drop the transfer and pulse cmd_err.
  - Otherwise decode from the synchronized rs/data.
- Instruction decode uses the highest set bit of data:
  - 0x01 Clear: enter CLEAR.
  - 0x02/0x03 Home: AC=0, busy for CLR_CYCLES.
  - 0x04-0x07 Entry Mode: I/D=data[1]. S=data[0] is stored but has no effect; display shift is not supported.
  - 0x08-0x0F: disp_on/cursor_on/blink_on = data[2:0].
  - 0x10-0x1F Cursor Shift: when data[3]=0, move AC by ±1 per data[2] using the wrap rules below. When data[3]=1 (display shift), do nothing.
  - 0x20-0x3F Function Set: if data[4] and data[3] are both 1, set init_done.
  - 0x40-0x7F CGRAM address: accept the transfer; it has no effect.
  - 0x80-0xFF: AC = data[6:0].
- Data write (rs=1):
  - If AC is in 0x00-0x0F, store to cell AC.
  - If AC is in 0x40-0x4F, store to cell AC-0x40+16.
  - Any other AC: discard the data.
  - In every case, step AC by I/D.
- AC step rules:
  - Increment: 0x27 goes to 0x40; 0x67 goes to 0x00.
  - Decrement: 0x40 goes to 0x27; 0x00 goes to 0x67.
  - A Set-DDRAM address in 0x28-0x3F or 0x68-0x7F is loaded as given. Its next increment goes to 0x40 or 0x00 respectively; its next decrement goes to 0x27 or 0x67.
- State machine:
  - IDLE: wait for an edge.
  - EXEC: count down BUSY_CYCLES or CLR_CYCLES, then return to IDLE.
  - CLEAR: write 0x20 to cells 0..31, one cell per cycle (32 cycles). Set AC=0 and I/D=1, then go to EXEC with CLR_CYCLES.
- Reset values:
  - All 32 cells = 0x20 (space); rd_char = 0x20.
  - AC = 0, I/D = 1, S = 0.
  - disp_on, cursor_on, blink_on, busy, cmd_err, init_done = 0.
  - State = IDLE; all synchronizer and edge registers = 0.

## Timing
- Let E be the first clk rising edge after the lcd_en pin falls. Edge detection happens at E+2.
- At E+2, in the same cycle: the DDRAM write, AC update and flag update take effect, busy rises, and cmd_err pulses when the transfer is dropped.
- rd_char = cell[rd_addr] sampled at the previous edge, giving 1-cycle read latency. A write to the cell under rd_addr is visible at E+3.
- busy stays high for exactly BUSY_CYCLES cycles after a normal transfer. After Clear it stays high for 32 + CLR_CYCLES cycles.
- rs/rw/data must be stable from lcd_en rise until 3 clk after lcd_en fall. The upstream writer holds them for ≥1 ms.
- Reset asserted mid-CLEAR or mid-EXEC returns to the reset values immediately; a partial clear is abandoned.
- An edge arriving in the same cycle that busy falls is dropped: busy is evaluated before it is cleared.

## Test plan
- Init sequence: send 0x38, 0x0E, 0x06, 0x01, 0x80 with ≥2 ms spacing. Expect init_done=1, disp_on=1, cursor_on=1, blink_on=0, AC=0, and all cells 0x20.
- Write "2019-01-01" after 0x80. Expect cells 0-9 to read back '2','0','1','9','-','0','1','-','0','1' and AC=0x0A.
- Send 0xC0, then "CLOCK". Expect cells 16-20 = "CLOCK" and AC=0x45; cells 0-15 unchanged.
- Send 0xA7 then data 'X'. Expect no cell changed and AC=0x40. Then send 0x04 and data 'Y'. Expect cell 16 = 'Y' and AC=0x27.
- Send a second transfer 10 cycles after the first (BUSY_CYCLES=2000). Expect a cmd_err pulse, the second transfer's data not stored, and AC advanced only once.
- Send 0x01, then assert rst 10 cycles into CLEAR. Expect busy=0, AC=0, all cells 0x20, and state IDLE. A subsequent data write lands in cell 0.

Source files
------------

// File: rtl/lcd1602_responder.sv
// HD44780-style 8-bit LCD write-bus responder: shadow DDRAM (32 cells), address counter, display flags.
// Transfer takes effect 2 clk after the first clk edge past lcd_en fall; transfers arriving while busy are dropped with a cmd_err pulse.
module lcd1602_responder #(
    parameter int BUSY_CYCLES = 2000,
    parameter int CLR_CYCLES  = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic [6:0] cursor_pos,
    output logic       busy,
    output logic       cmd_err,
    output logic       init_done
);

    localparam int MAX_CYCLES = (CLR_CYCLES > BUSY_CYCLES) ? CLR_CYCLES : BUSY_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] BUSY_LOAD = CW'(BUSY_CYCLES - 1);
    localparam logic [CW-1:0] CLR_LOAD  = CW'(CLR_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR} state_t;

    // Address counter walks 0x00-0x27 and 0x40-0x67; anything past column 0x27 folds to the line boundary.
    function automatic logic [6:0] ac_inc(input logic [6:0] a);
        if (a[5:0] >= 6'h27) return {~a[6], 6'h00};
        return a + 7'd1;
    endfunction

    function automatic logic [6:0] ac_dec(input logic [6:0] a);
        if (a[5:0] == 6'h00) return {~a[6], 6'h27};
        if (a[5:0] > 6'h27)  return {a[6], 6'h27};
        return a - 7'd1;
    endfunction

    logic       en_s1_q, en_s2_q, en_s3_q;
    logic       rs_s1_q, rs_s2_q;
    logic       rw_s1_q, rw_s2_q;
    logic [7:0] dat_s1_q, dat_s2_q;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      clr_idx_q, clr_idx_d;
    logic [6:0]      ac_q, ac_d;
    logic            id_q, id_d;
    logic            s_q, s_d;
    logic            disp_q, disp_d;
    logic            cur_q, cur_d;
    logic            blink_q, blink_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic            init_q, init_d;
    logic [7:0]      mem_q [32];
    logic [7:0]      rd_char_q;

    logic            mem_we;
    logic [4:0]      mem_waddr;
    logic [7:0]      mem_wdat;
    logic            en_fall;

    assign en_fall = en_s3_q & ~en_s2_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_idx_d = clr_idx_q;
        ac_d      = ac_q;
        id_d      = id_q;
        s_d       = s_q;
        disp_d    = disp_q;
        cur_d     = cur_q;
        blink_d   = blink_q;
        busy_d    = busy_q;
        err_d     = 1'b0;
        init_d    = init_q;
        mem_we    = 1'b0;
        mem_waddr = 5'd0;
        mem_wdat  = 8'h00;

        case (state_q)
            S_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_idx_q;
                mem_wdat  = 8'h20;
                clr_idx_d = clr_idx_q + 5'd1;
                if (clr_idx_q == 5'd31) begin
                    ac_d    = 7'h00;
                    id_d    = 1'b1;
                    state_d = S_EXEC;
                    cnt_d   = CLR_LOAD;
                end
            end
            default: ;
        endcase

        // busy_q is checked before the EXEC countdown clears it, so an edge coinciding with busy falling is dropped.
        if (en_fall && !rw_s2_q) begin
            if (busy_q) begin
                err_d = 1'b1;
            end else begin
                busy_d  = 1'b1;
                state_d = S_EXEC;
                cnt_d   = BUSY_LOAD;
                if (rs_s2_q) begin
                    if (ac_q[5:4] == 2'b00) begin
                        mem_we    = 1'b1;
                        mem_waddr = {ac_q[6], ac_q[3:0]};
                        mem_wdat  = dat_s2_q;
                    end
                    ac_d = id_q ? ac_inc(ac_q) : ac_dec(ac_q);
                end else begin
                    casez (dat_s2_q)
                        8'b1???????: ac_d = dat_s2_q[6:0];
                        8'b01??????: ;
                        8'b001?????: if (dat_s2_q[4] && dat_s2_q[3]) init_d = 1'b1;
                        8'b0001????: if (!dat_s2_q[3]) ac_d = dat_s2_q[2] ? ac_inc(ac_q) : ac_dec(ac_q);
                        8'b00001???: {disp_d, cur_d, blink_d} = dat_s2_q[2:0];
                        8'b000001??: {id_d, s_d} = dat_s2_q[1:0];
                        8'b0000001?: begin
                            ac_d  = 7'h00;
                            cnt_d = CLR_LOAD;
                        end
                        8'b00000001: begin
                            state_d   = S_CLEAR;
                            clr_idx_d = 5'd0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_s1_q   <= 1'b0;
            en_s2_q   <= 1'b0;
            en_s3_q   <= 1'b0;
            rs_s1_q   <= 1'b0;
            rs_s2_q   <= 1'b0;
            rw_s1_q   <= 1'b0;
            rw_s2_q   <= 1'b0;
            dat_s1_q  <= 8'h00;
            dat_s2_q  <= 8'h00;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            clr_idx_q <= 5'd0;
            ac_q      <= 7'h00;
            id_q      <= 1'b1;
            s_q       <= 1'b0;
            disp_q    <= 1'b0;
            cur_q     <= 1'b0;
            blink_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            init_q    <= 1'b0;
            rd_char_q <= 8'h20;
            for (int i = 0; i < 32; i++) mem_q[i] <= 8'h20;
        end else begin
            en_s1_q   <= lcd_en;
            en_s2_q   <= en_s1_q;
            en_s3_q   <= en_s2_q;
            rs_s1_q   <= lcd_rs;
            rs_s2_q   <= rs_s1_q;
            rw_s1_q   <= lcd_rw;
            rw_s2_q   <= rw_s1_q;
            dat_s1_q  <= lcd_data;
            dat_s2_q  <= dat_s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clr_idx_q <= clr_idx_d;
            ac_q      <= ac_d;
            id_q      <= id_d;
            s_q       <= s_d;
            disp_q    <= disp_d;
            cur_q     <= cur_d;
            blink_q   <= blink_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            init_q    <= init_d;
            rd_char_q <= mem_q[rd_addr];
            if (mem_we) mem_q[mem_waddr] <= mem_wdat;
        end
    end

    assign rd_char    = rd_char_q;
    assign disp_on    = disp_q;
    assign cursor_on  = cur_q;
    assign blink_on   = blink_q;
    assign cursor_pos = ac_q;
    assign busy       = busy_q;
    assign cmd_err    = err_q;
    assign init_done  = init_q;

endmodule

// File: tb/tb_lcd1602_responder.sv
// Bench for lcd1602_responder: directed LCD bus sequences plus random transfers against a screen/cursor model.
module tb_lcd1602_responder;

    localparam int BUSY = 20;
    localparam int CLR  = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
    logic [7:0] lcd_data = 8'h00;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_char;
    logic       disp_on, cursor_on, blink_on, busy, cmd_err, init_done;
    logic [6:0] cursor_pos;

    lcd1602_responder #(.BUSY_CYCLES(BUSY), .CLR_CYCLES(CLR)) dut (
        .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_char(rd_char),
        .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .cursor_pos(cursor_pos), .busy(busy), .cmd_err(cmd_err), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Reference model of the display as seen from the bus.
    logic [7:0] m_cell [32];
    int  m_ac;
    bit  m_id, m_d, m_c, m_b, m_init;
    int  busy_fall;
    int  clr_done;
    int  last_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_cell[i] = 8'h20;
        m_ac = 0; m_id = 1; m_d = 0; m_c = 0; m_b = 0; m_init = 0;
        busy_fall = -1; clr_done = -1;
    endtask

    // Line is 0 or 1 (base 0x00 / 0x40); visible columns 0..39.
    function automatic int m_step(input int a, input bit up);
        int line, col;
        line = a / 64;
        col  = a % 64;
        if (up) return (col >= 39) ? (line == 1 ? 0 : 64) : a + 1;
        if (col == 0) return (line == 1) ? 39 : 64 + 39;
        if (col > 39) return line * 64 + 39;
        return a - 1;
    endfunction

    task automatic xfer(input bit rs, input bit rw, input logic [7:0] d, input int fall_at);
        int  t, hb;
        bit  drop;
        drop = 0;
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
        repeat (2) @(negedge clk);
        while (cyc < fall_at) @(negedge clk);
        lcd_en = 1'b0;
        t = cyc + 3;
        last_t = t;
        if (!rw) begin
            if (t <= busy_fall) drop = 1;
            else if (rs) begin
                if (m_ac < 16) m_cell[m_ac] = d;
                else if (m_ac >= 64 && m_ac < 80) m_cell[m_ac - 48] = d;
                m_ac = m_step(m_ac, m_id);
                busy_fall = t + BUSY;
            end else begin
                hb = -1;
                for (int b = 0; b < 8; b++) if (d[b]) hb = b;
                busy_fall = t + BUSY;
                case (hb)
                    0: begin
                        for (int i = 0; i < 32; i++) m_cell[i] = 8'h20;
                        m_ac = 0; m_id = 1;
                        busy_fall = t + 32 + CLR;
                        clr_done = t + 32;
                    end
                    1: begin m_ac = 0; busy_fall = t + CLR; end
                    2: m_id = d[1];
                    3: begin m_d = d[2]; m_c = d[1]; m_b = d[0]; end
                    4: if (!d[3]) m_ac = m_step(m_ac, d[2]);
                    5: if (d[4] && d[3]) m_init = 1;
                    7: m_ac = int'(d[6:0]);
                    default: ;
                endcase
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("cmd_err", cmd_err, drop);
        chk("busy", busy, (t < busy_fall));
        chk("disp_on", disp_on, m_d);
        chk("cursor_on", cursor_on, m_c);
        chk("blink_on", blink_on, m_b);
        chk("init_done", init_done, m_init);
        if (t >= clr_done) chk("cursor_pos", cursor_pos, m_ac);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        while (cyc < busy_fall) @(negedge clk);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_cursor", cursor_pos, m_ac);
    endtask

    task automatic check_screen();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rd_addr = 5'(i);
            @(negedge clk);
            chk($sformatf("cell%0d", i), rd_char, m_cell[i]);
        end
    endtask

    task automatic send(input bit rs, input logic [7:0] d);
        xfer(rs, 1'b0, d, 0);
        wait_idle();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(1'b1, s[i]);
    endtask

    initial begin
        logic [7:0] d;
        bit rs, rw;
        int r;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_rd_char", rd_char, 8'h20);
        chk("rst_busy", busy, 0);
        chk("rst_cursor", cursor_pos, 0);
        chk("rst_flags", {disp_on, cursor_on, blink_on, init_done, cmd_err}, 5'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        send(0, 8'h38); send(0, 8'h0E); send(0, 8'h06); send(0, 8'h01); send(0, 8'h80);
        chk("init_init_done", init_done, 1);
        chk("init_disp", {disp_on, cursor_on, blink_on}, 3'b110);
        chk("init_ac", cursor_pos, 0);
        check_screen();

        send_str("2019-01-01");
        chk("date_ac", cursor_pos, 7'h0A);
        send(0, 8'hC0);
        send_str("CLOCK");
        chk("clock_ac", cursor_pos, 7'h45);
        check_screen();

        send(0, 8'hA7); send(1, "X");
        chk("wrap_ac", cursor_pos, 7'h40);
        send(0, 8'h04); send(1, "Y");
        chk("dec_ac", cursor_pos, 7'h27);
        check_screen();
        send(0, 8'h06); send(0, 8'h80);

        // Second transfer 10 cycles after the first lands while busy.
        xfer(1, 0, "A", 0);
        xfer(1, 0, "B", last_t + 7);
        wait_idle();
        chk("drop_ac", cursor_pos, 7'h01);
        // Edge exactly on the cycle busy falls is dropped; one cycle later is accepted.
        xfer(1, 0, "C", 0);
        xfer(1, 0, "D", busy_fall - 3);
        xfer(1, 0, "E", busy_fall - 2);
        wait_idle();
        check_screen();

        for (int n = 0; n < 80; n++) begin
            rw = ($urandom_range(0, 7) == 0);
            rs = 1'($urandom_range(0, 1));
            if (rs) d = 8'($urandom_range(8'h21, 8'h7E));
            else begin
                r = $urandom_range(0, 19);
                d = 8'($urandom);
                case (r)
                    0: d = 8'h01;
                    1: d = 8'h02 | (d & 8'h01);
                    2, 3: d = 8'h04 | (d & 8'h03);
                    4, 5: d = 8'h08 | (d & 8'h07);
                    6, 7, 8: d = 8'h10 | (d & 8'h0F);
                    9: d = 8'h20 | (d & 8'h1F);
                    10: d = 8'h40 | (d & 8'h3F);
                    default: d = 8'h80 | d;
                endcase
            end
            xfer(rs, rw, d, 0);
            repeat ($urandom_range(0, 30)) @(negedge clk);
            if (n % 16 == 15) begin
                wait_idle();
                check_screen();
            end
        end
        wait_idle();
        check_screen();

        send(0, 8'h80); send_str("ZZ");
        xfer(0, 0, 8'h01, 0);
        while (cyc < last_t + 10) @(negedge clk);
        rst = 1'b0;
        #1;
        m_reset();
        chk("rstclr_busy", busy, 0);
        chk("rstclr_ac", cursor_pos, 0);
        chk("rstclr_init", init_done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_screen();
        send(1, "Q");
        chk("after_rst_ac", cursor_pos, 7'h01);
        check_screen();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
